sensors_height_avg: RTL and testbench

Parametrised successor of the four-sensor height front end. Accepts one snapshot of `2*NUM_PAIRS` sensor readings per handshake, discards every opposing pair that contains a zero (faulty) reading, and produces the rounded-half-up mean of the remaining readings. It sits between the sensor sampling logic and the baggage-drop weight/height checker. It accumulates sequentially, one pair per cycle, and divides with a multi-cycle restoring divider, so any pair count is supported without a wide combinational adder tree.

---
 rtl/sensors_pkg.sv | 23 ++
 rtl/seq_divider.sv | 59 +++++
 rtl/sensors_height_avg.sv | 157 +++++++++++++++
 tb/tb_sensors_height_avg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sensors_pkg.sv
// Shared types and helpers for the sensor front ends: FSM encoding,
// accumulator width derivation and the opposing-pair reading map.
package sensors_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Accumulator width: enough headroom for 2*num_pairs full-scale readings plus rounding bias.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned num_pairs);
    return width + $clog2(2 * num_pairs);
  endfunction

  // Reading index of one side of pair p; side 1 is the opposing sensor.
  function automatic int unsigned pair_reading(input int unsigned p, input int unsigned num_pairs,
                                               input logic side);
    return side ? p + num_pairs : p;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first.
// done_c/quotient_c present the final result combinationally during the last step.
module seq_divider #(
  parameter int unsigned DVD_W = 10,
  parameter int unsigned DVS_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done_c,
  output logic [DVD_W-1:0] quotient_c
);

  localparam int unsigned CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W:0]   shifted_c;
  logic [DVS_W:0]   diff_c;
  logic             qbit_c;
  logic [DVS_W-1:0] rem_next_c;

  // Partial remainder stays below the divisor, so DVS_W bits always suffice.
  always_comb begin
    shifted_c  = {rem_q, dvd_q[DVD_W-1]};
    diff_c     = shifted_c - {1'b0, dvs_q};
    qbit_c     = (shifted_c >= {1'b0, dvs_q});
    rem_next_c = qbit_c ? DVS_W'(diff_c) : DVS_W'(shifted_c);
    quotient_c = {dvd_q[DVD_W-2:0], qbit_c};
    done_c     = busy && (cnt_q == CNT_W'(DVD_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      dvd_q <= quotient_c;
      rem_q <= rem_next_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/sensors_height_avg.sv
// Height front end: drops opposing pairs with a faulty (zero) reading and
// returns the round-half-up mean of the rest, one pair per cycle.
module sensors_height_avg
  import sensors_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_PAIRS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2*NUM_PAIRS*WIDTH-1:0]       sensors,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   height,
  output logic [$clog2(NUM_PAIRS+1)-1:0]     pairs_used,
  output logic                               no_valid
);

  localparam int unsigned SUM_W  = sum_width(WIDTH, NUM_PAIRS);
  localparam int unsigned CNT_W  = $clog2(NUM_PAIRS + 1);
  localparam int unsigned IDX_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned SNAP_W = 2 * NUM_PAIRS * WIDTH;
  localparam int unsigned DVS_W  = CNT_W + 1;

  state_t             state_q, state_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   height_d;
  logic [CNT_W-1:0]   pairs_used_d;
  logic               no_valid_d;
  logic               out_valid_d;

  logic [WIDTH-1:0]   a_c, b_c;
  logic               pair_ok_c;
  logic               last_pair_c;
  logic [SUM_W-1:0]   acc_sum_c;
  logic [CNT_W-1:0]   cnt_sum_c;
  logic               div_start_c;
  logic [SUM_W-1:0]   div_dividend_c;
  logic [DVS_W-1:0]   div_divisor_c;
  logic               div_busy;
  logic               div_done_c;
  logic [SUM_W-1:0]   div_quot_c;

  assign in_ready = (state_q == IDLE) && !div_busy;

  // Current pair and its contribution; idx never passes NUM_PAIRS-1.
  always_comb begin
    a_c            = snap_q[pair_reading(32'(idx_q), NUM_PAIRS, 1'b0) * WIDTH +: WIDTH];
    b_c            = snap_q[pair_reading(32'(idx_q), NUM_PAIRS, 1'b1) * WIDTH +: WIDTH];
    pair_ok_c      = (a_c != '0) && (b_c != '0);
    last_pair_c    = (idx_q == IDX_W'(NUM_PAIRS - 1));
    acc_sum_c      = acc_q + (pair_ok_c ? (SUM_W'(a_c) + SUM_W'(b_c)) : SUM_W'(0));
    cnt_sum_c      = cnt_q + CNT_W'(pair_ok_c);
    div_dividend_c = acc_sum_c + SUM_W'(cnt_sum_c);
    div_divisor_c  = {cnt_sum_c, 1'b0};
  end

  seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (DVS_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (div_start_c),
    .dividend   (div_dividend_c),
    .divisor    (div_divisor_c),
    .busy       (div_busy),
    .done_c     (div_done_c),
    .quotient_c (div_quot_c)
  );

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    height_d     = height;
    pairs_used_d = pairs_used;
    no_valid_d   = no_valid;
    out_valid_d  = out_valid;
    div_start_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          snap_d  = sensors;
          acc_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum_c;
        cnt_d = cnt_sum_c;
        if (!last_pair_c) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (cnt_sum_c == '0) begin
          height_d     = '0;
          pairs_used_d = '0;
          no_valid_d   = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          div_start_c = 1'b1;
          state_d     = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done_c) begin
          height_d     = WIDTH'(div_quot_c);
          pairs_used_d = cnt_q;
          no_valid_d   = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      height     <= '0;
      pairs_used <= '0;
      no_valid   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      height     <= height_d;
      pairs_used <= pairs_used_d;
      no_valid   <= no_valid_d;
      out_valid  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sensors_height_avg.sv
// Scoreboard bench for sensors_height_avg: default instance plus a NUM_PAIRS=3 instance.
module tb_sensors_height_avg;

  typedef struct {
    int h;
    int p;
    int nv;
    int lat;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, no_valid2;
  logic [31:0] sensors2;
  logic [7:0]  height2;
  logic [1:0]  pairs_used2;
  logic        in_valid3, in_ready3, out_valid3, out_ready3, no_valid3;
  logic [47:0] sensors3;
  logic [7:0]  height3;
  logic [1:0]  pairs_used3;

  exp_t q2[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic ov2_prev = 1'b0;
  logic ov3_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sensors_height_avg #(.WIDTH(8), .NUM_PAIRS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .sensors(sensors2), .out_valid(out_valid2), .out_ready(out_ready2),
    .height(height2), .pairs_used(pairs_used2), .no_valid(no_valid2)
  );

  sensors_height_avg #(.WIDTH(8), .NUM_PAIRS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .sensors(sensors3), .out_valid(out_valid3), .out_ready(out_ready3),
    .height(height3), .pairs_used(pairs_used3), .no_valid(no_valid3)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] p4(input logic [7:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic send2(input logic [31:0] s, input bit push, input int h, p, nv, lat);
    int n = 0;
    while (!in_ready2 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready2) begin timeout("send2_ready"); return; end
    sensors2  = s;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    if (push) q2.push_back('{h, p, nv, lat, cyc});
  endtask

  task automatic send3(input logic [47:0] s, input int h, p, nv, lat);
    int n = 0;
    while (!in_ready3 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready3) begin timeout("send3_ready"); return; end
    sensors3  = s;
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    q3.push_back('{h, p, nv, lat, cyc});
  endtask

  // Monitors: compare each newly presented result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid2 && !ov2_prev) begin
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL np2_unexpected: result h=%0d with empty scoreboard", height2);
      end else begin
        e = q2.pop_front();
        chk("np2_height", int'(height2), e.h);
        chk("np2_pairs_used", int'(pairs_used2), e.p);
        chk("np2_no_valid", int'(no_valid2), e.nv);
        chk("np2_latency", cyc - e.acc, e.lat);
      end
    end
    ov2_prev = out_valid2;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid3 && !ov3_prev) begin
      if (q3.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL np3_unexpected: result h=%0d with empty scoreboard", height3);
      end else begin
        e = q3.pop_front();
        chk("np3_height", int'(height3), e.h);
        chk("np3_pairs_used", int'(pairs_used3), e.p);
        chk("np3_no_valid", int'(no_valid3), e.nv);
        chk("np3_latency", cyc - e.acc, e.lat);
      end
    end
    ov3_prev = out_valid3;
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid2 = 1'b0; in_valid3 = 1'b0;
    out_ready2 = 1'b1; out_ready3 = 1'b1;
    sensors2 = '0; sensors3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready2), 1);
    chk("reset_out_valid", int'(out_valid2), 0);
    chk("reset_height", int'(height2), 0);
    chk("reset_no_valid", int'(no_valid2), 0);
    chk("reset_in_ready_np3", int'(in_ready3), 1);

    send2(p4(10, 11, 12, 13), 1, 12, 2, 0, 12);
    send2(p4(0, 7, 5, 8), 1, 8, 1, 0, 12);
    send2(p4(0, 0, 0, 0), 1, 0, 0, 1, 2);
    send2(p4(1, 2, 2, 2), 1, 2, 2, 0, 12);

    // Output stall: result held, input ignored.
    n = 0;
    while (!in_ready2 && n < 200) begin @(negedge clk); n++; end
    out_ready2 = 1'b0;
    send2(p4(255, 255, 255, 255), 1, 255, 2, 0, 12);
    n = 0;
    while (!out_valid2 && n < 60) begin @(negedge clk); n++; end
    if (!out_valid2) timeout("stall_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid2), 1);
      chk("stall_height", int'(height2), 255);
      chk("stall_in_ready", int'(in_ready2), 0);
      if (i == 1) begin sensors2 = p4(1, 1, 1, 1); in_valid2 = 1'b1; end
      else in_valid2 = 1'b0;
    end
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(out_valid2), 0);
    chk("release_in_ready", int'(in_ready2), 1);
    chk("release_height_kept", int'(height2), 255);

    // Reset while dividing: snapshot discarded.
    send2(p4(10, 11, 12, 13), 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", int'(out_valid2), 0);
    chk("midrst_height", int'(height2), 0);
    chk("midrst_pairs_used", int'(pairs_used2), 0);
    chk("midrst_no_valid", int'(no_valid2), 0);
    chk("midrst_in_ready", int'(in_ready2), 1);
    send2(p4(4, 4, 4, 4), 1, 4, 2, 0, 12);

    send3({8'd6, 8'd5, 8'd3, 8'd6, 8'd0, 8'd9}, 6, 2, 0, 14);

    n = 0;
    while ((q2.size() != 0 || q3.size() != 0) && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("np2_scoreboard_drained", q2.size(), 0);
    chk("np3_scoreboard_drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
